// File: rtl/tlp_frag_engine_if.sv
// rtl/tlp_frag_engine_if.sv - buffer, ECRC and DLL handshake bundle for the TX fragmentation engine
interface tlp_frag_engine_if #(
  parameter int OUT_DW = 8
);
  localparam int VB_W = $clog2(OUT_DW * 4);

  logic                  entry_valid;
  logic [129:0]          entry_data;
  logic                  entry_pop;
  logic                  ecrc_valid;
  logic [31:0]           ecrc_data;
  logic                  ecrc_ack;
  logic                  dll_valid;
  logic                  dll_ready;
  logic [OUT_DW*32-1:0]  dll_data;
  logic                  dll_sot;
  logic                  dll_eot;
  logic [VB_W-1:0]       dll_valid_bytes;
  logic                  err_frame;

  modport slave (
    input  entry_valid, entry_data, ecrc_valid, ecrc_data, dll_ready,
    output entry_pop, ecrc_ack, dll_valid, dll_data, dll_sot, dll_eot,
           dll_valid_bytes, err_frame
  );

  modport master (
    output entry_valid, entry_data, ecrc_valid, ecrc_data, dll_ready,
    input  entry_pop, ecrc_ack, dll_valid, dll_data, dll_sot, dll_eot,
           dll_valid_bytes, err_frame
  );
endinterface

// File: rtl/tlp_frag_engine.sv
// rtl/tlp_frag_engine.sv - packs one TLP from 4DW buffer entries into OUT_DW-wide DLL beats
// Header DW0 sets the DW count; an optional ECRC DW is appended after the last data DW.
module tlp_frag_engine #(
  parameter int OUT_DW   = 8,
  parameter int ENTRY_DW = 4,
  parameter int ECRC_EN  = 1
) (
  input logic              clk,
  input logic              rst_n,
  tlp_frag_engine_if.slave io_bus
);
  localparam int SLOTS = OUT_DW / ENTRY_DW;
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int KW    = $clog2(OUT_DW);
  localparam int CW    = KW + 1;
  localparam int VB_W  = $clog2(OUT_DW * 4);
  localparam int BW    = OUT_DW * 32;
  localparam int EW    = ENTRY_DW * 32;

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_ECRC_WAIT, S_SEND, S_ECRC_ONLY
  } state_t;

  state_t          r_state, w_next;
  logic [BW-1:0]   r_beat, w_beat_ld;
  logic [10:0]     r_rem, r_tdata;
  logic            r_td, r_first, r_eot, r_err;
  logic [SW-1:0]   r_slot;
  logic [CW-1:0]   r_dws;

  logic            w_idle, w_sot, w_eot, w_td_new, w_td;
  logic [10:0]     w_hdr, w_len, w_tdata_new, w_tdata, w_rem_in;
  logic            w_done, w_full, w_load, w_pop, w_ack, w_ferr, w_valid;
  logic [SW-1:0]   w_slot;
  logic [KW-1:0]   w_tail, w_dm1;

  assign w_idle = (r_state == S_IDLE);
  assign w_sot  = io_bus.entry_data[129];
  assign w_eot  = io_bus.entry_data[128];

  // DW0 sits at [127:96]: fmt[1:0]=[126:125], TD=[111], Length=[105:96]
  assign w_hdr       = io_bus.entry_data[125] ? 11'd4 : 11'd3;
  assign w_len       = (io_bus.entry_data[105:96] == 10'd0) ? 11'd1024
                                                            : {1'b0, io_bus.entry_data[105:96]};
  assign w_tdata_new = w_hdr + (io_bus.entry_data[126] ? w_len : 11'd0);
  assign w_td_new    = io_bus.entry_data[111] && (ECRC_EN != 0);

  assign w_tdata  = w_idle ? w_tdata_new : r_tdata;
  assign w_td     = w_idle ? w_td_new : r_td;
  assign w_rem_in = w_idle ? w_tdata_new : r_rem;
  assign w_slot   = w_idle ? '0 : r_slot;
  assign w_done   = (w_rem_in <= 11'd4);
  assign w_full   = (w_slot == SW'(SLOTS - 1));
  assign w_tail   = w_tdata[KW-1:0];

  always_comb begin
    w_beat_ld = w_idle ? '0 : r_beat;
    w_beat_ld[(SLOTS - 1 - int'(w_slot)) * EW +: EW] = io_bus.entry_data[EW-1:0];
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_load = 1'b0;
    w_ack  = 1'b0;
    w_ferr = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (io_bus.entry_valid) begin
          w_pop = 1'b1;
          if (w_sot) begin
            w_load = 1'b1;
            w_ferr = (w_eot != w_done);
          end else begin
            w_ferr = 1'b1;
          end
        end
      end
      S_COLLECT: begin
        if (io_bus.entry_valid) begin
          w_pop  = 1'b1;
          w_load = 1'b1;
          w_ferr = w_sot || (w_eot != w_done);
        end
      end
      S_ECRC_WAIT, S_ECRC_ONLY: begin
        if (io_bus.ecrc_valid) begin
          w_ack  = 1'b1;
          w_next = S_SEND;
        end
      end
      S_SEND: begin
        if (io_bus.dll_ready) begin
          if (r_eot)
            w_next = S_IDLE;
          else if (r_rem == 11'd0)
            w_next = S_ECRC_ONLY;
          else
            w_next = S_COLLECT;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // ECRC joins the last data beat only when that beat still has a free DW
    if (w_load) begin
      if (w_done)
        w_next = (w_td && (w_tail != '0)) ? S_ECRC_WAIT : S_SEND;
      else if (w_full)
        w_next = S_SEND;
      else
        w_next = S_COLLECT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat  <= '0;
      r_rem   <= '0;
      r_tdata <= '0;
      r_td    <= 1'b0;
      r_first <= 1'b0;
      r_eot   <= 1'b0;
      r_err   <= 1'b0;
      r_slot  <= '0;
      r_dws   <= '0;
    end else begin
      r_err <= w_ferr;
      if (w_load) begin
        r_beat <= w_beat_ld;
        r_slot <= w_slot + SW'(1);
        r_rem  <= w_done ? 11'd0 : (w_rem_in - 11'd4);
        if (w_idle) begin
          r_tdata <= w_tdata_new;
          r_td    <= w_td_new;
          r_first <= 1'b1;
        end
        r_eot <= w_done && !w_td;
        r_dws <= (w_done && (w_tail != '0)) ? CW'(w_tail) : CW'(OUT_DW);
      end else if (w_ack) begin
        if (r_state == S_ECRC_ONLY) begin
          r_beat <= {io_bus.ecrc_data, {(BW-32){1'b0}}};
          r_dws  <= CW'(1);
        end else begin
          r_beat[(OUT_DW - 1 - int'(w_tail)) * 32 +: 32] <= io_bus.ecrc_data;
          r_dws <= r_dws + CW'(1);
        end
        r_eot <= 1'b1;
      end else if ((r_state == S_SEND) && io_bus.dll_ready) begin
        r_beat  <= '0;
        r_slot  <= '0;
        r_first <= 1'b0;
        r_eot   <= 1'b0;
      end
    end
  end

  assign w_valid = (r_state == S_SEND);
  assign w_dm1   = KW'(r_dws - CW'(1));

  assign io_bus.entry_pop       = w_pop && rst_n;
  assign io_bus.ecrc_ack        = w_ack && rst_n;
  assign io_bus.err_frame       = r_err;
  assign io_bus.dll_valid       = w_valid;
  assign io_bus.dll_data        = w_valid ? r_beat : '0;
  assign io_bus.dll_sot         = w_valid && r_first;
  assign io_bus.dll_eot         = w_valid && r_eot;
  assign io_bus.dll_valid_bytes = w_valid ? VB_W'({w_dm1, 2'b11}) : '0;
endmodule

// File: tb/tb_tlp_frag_engine.sv
// tb/tb_tlp_frag_engine.sv - self-checking bench for tlp_frag_engine with OUT_DW=8
module tb_tlp_frag_engine;
  localparam int OUT_DW = 8;
  localparam int BW     = OUT_DW * 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlp_frag_engine_if #(.OUT_DW(OUT_DW)) bus ();

  tlp_frag_engine #(.OUT_DW(OUT_DW), .ENTRY_DW(4), .ECRC_EN(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  typedef struct {
    logic [BW-1:0] d;
    logic [4:0]    vb;
    logic          sot;
    logic          eot;
  } beat_t;

  beat_t        exp_q[$];
  beat_t        log_q[$];
  logic [129:0] ent_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int ack_cnt = 0;
  int err_cnt = 0;
  logic        ecrc_pend = 1'b0;
  logic [31:0] ecrc_val = '0;
  int          ecrc_at = 0;
  int          rdy_lo_from = -1;
  int          rdy_lo_len = 0;

  task automatic chk(input string name, input logic [299:0] act, input logic [299:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [299:0] pk(input beat_t b);
    return 300'({b.vb, b.sot, b.eot, b.d});
  endfunction

  // Bench-side FWFT buffer, ECRC source and DLL sink; compares every accepted beat.
  initial begin
    beat_t b, held, e;
    logic stalled, do_pop, acked;
    stalled = 1'b0;
    bus.entry_valid = 1'b0;
    bus.entry_data  = '0;
    bus.ecrc_valid  = 1'b0;
    bus.ecrc_data   = '0;
    bus.dll_ready   = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      do_pop = 1'b0;
      acked  = 1'b0;
      b.d   = bus.dll_data;
      b.vb  = bus.dll_valid_bytes;
      b.sot = bus.dll_sot;
      b.eot = bus.dll_eot;
      if (rst_n) begin
        if (stalled) begin
          chk("stall_valid", bus.dll_valid, 1);
          chk("stall_hold", pk(b), pk(held));
        end
        chk("no_pop_in_send", bus.dll_valid & bus.entry_pop, 0);
        if (bus.err_frame) err_cnt++;
        if (bus.ecrc_ack) begin
          chk("ack_has_valid", bus.ecrc_valid, 1);
          ack_cnt++;
          acked = 1'b1;
        end
        if (bus.entry_pop) begin
          chk("pop_has_entry", bus.entry_valid, 1);
          pop_cnt++;
          do_pop = 1'b1;
        end
        if (bus.dll_valid && bus.dll_ready) begin
          chk("beat_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("beat", pk(b), pk(e));
          end
          log_q.push_back(b);
        end
        stalled = bus.dll_valid && !bus.dll_ready;
        held = b;
      end else begin
        stalled = 1'b0;
      end
      @(posedge clk);
      #1;
      if (do_pop && ent_q.size() > 0) void'(ent_q.pop_front());
      if (acked) ecrc_pend = 1'b0;
      bus.entry_valid = (ent_q.size() > 0);
      bus.entry_data  = (ent_q.size() > 0) ? ent_q[0] : '0;
      bus.ecrc_valid  = ecrc_pend && (cyc >= ecrc_at);
      bus.ecrc_data   = ecrc_pend ? ecrc_val : 32'd0;
      bus.dll_ready   = !((cyc >= rdy_lo_from) && (cyc < rdy_lo_from + rdy_lo_len));
    end
  end

  task automatic start_test();
    pop_cnt = 0;
    ack_cnt = 0;
    err_cnt = 0;
    log_q.delete();
  endtask

  // Model: the TLP is a flat DW stream (data then ECRC) cut into OUT_DW-sized beats.
  task automatic add_tlp(input logic [2:0] fmt, input int len, input logic td,
                         input logic drop_eot, input logic [31:0] ecrc, input int ecrc_delay);
    logic [31:0]  dws[$];
    logic [31:0]  dw0;
    logic [129:0] en;
    beat_t        bt;
    int h, l, t, nent, n;
    dw0 = '0;
    dw0[31:29] = fmt;
    dw0[15]    = td;
    dw0[9:0]   = len[9:0];
    h = fmt[0] ? 4 : 3;
    l = (len == 0) ? 1024 : len;
    t = h + (fmt[1] ? l : 0);
    dws.push_back(dw0);
    for (int i = 1; i < h; i++) dws.push_back(32'h1111_0000 + i);
    while (dws.size() < t) dws.push_back(32'hDA7A_0000 + dws.size() - h);
    nent = (t + 3) / 4;
    for (int en_i = 0; en_i < nent; en_i++) begin
      en = '0;
      en[129] = (en_i == 0);
      en[128] = (en_i == nent - 1) && !drop_eot;
      for (int j = 0; j < 4; j++)
        if (4 * en_i + j < t) en[127 - 32 * j -: 32] = dws[4 * en_i + j];
      ent_q.push_back(en);
    end
    if (td) begin
      dws.push_back(ecrc);
      ecrc_val  = ecrc;
      ecrc_at   = cyc + ecrc_delay;
      ecrc_pend = 1'b1;
    end
    for (int bi = 0; bi < dws.size(); bi += OUT_DW) begin
      n = (dws.size() - bi < OUT_DW) ? dws.size() - bi : OUT_DW;
      bt.d = '0;
      for (int k = 0; k < n; k++) bt.d[BW - 1 - 32 * k -: 32] = dws[bi + k];
      bt.vb  = 5'(4 * n - 1);
      bt.sot = (bi == 0);
      bt.eot = (bi + n == dws.size());
      exp_q.push_back(bt);
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || ent_q.size() > 0 || ecrc_pend) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk(name, n < 3000, 1);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_valid"}, bus.dll_valid, 0);
    chk({name, "_pop"}, bus.entry_pop, 0);
    chk({name, "_ack"}, bus.ecrc_ack, 0);
    chk({name, "_err"}, bus.err_frame, 0);
    chk({name, "_data"}, bus.dll_data, 0);
    chk({name, "_vb"}, bus.dll_valid_bytes, 0);
    chk({name, "_sot_eot"}, {bus.dll_sot, bus.dll_eot}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("init");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    start_test();
    add_tlp(3'b000, 1, 1'b0, 1'b0, 32'd0, 0);
    wait_done("t1_done");
    chk("t1_beats", log_q.size(), 1);
    if (log_q.size() > 0) begin
      chk("t1_vb", log_q[0].vb, 11);
      chk("t1_flags", {log_q[0].sot, log_q[0].eot}, 2'b11);
      chk("t1_hdr", log_q[0].d[255:160], 96'h00000001_11110001_11110002);
      chk("t1_zero", log_q[0].d[159:0], 0);
    end

    start_test();
    add_tlp(3'b011, 4, 1'b0, 1'b0, 32'd0, 0);
    wait_done("t2_done");
    chk("t2_pops", pop_cnt, 2);
    chk("t2_beats", log_q.size(), 1);
    if (log_q.size() > 0) begin
      chk("t2_vb", log_q[0].vb, 31);
      chk("t2_tail", log_q[0].d[31:0], 32'hDA7A_0003);
    end

    start_test();
    add_tlp(3'b011, 4, 1'b1, 1'b0, 32'hEC00_0003, 0);
    wait_done("t3_done");
    chk("t3_acks", ack_cnt, 1);
    chk("t3_beats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t3_b0", {log_q[0].vb, log_q[0].sot, log_q[0].eot}, {5'd31, 2'b10});
      chk("t3_b1", {log_q[1].vb, log_q[1].sot, log_q[1].eot}, {5'd3, 2'b01});
      chk("t3_ecrc", log_q[1].d[255:224], 32'hEC00_0003);
    end

    start_test();
    add_tlp(3'b010, 1, 1'b1, 1'b0, 32'hEC00_0004, 6);
    wait_done("t4_done");
    chk("t4_acks", ack_cnt, 1);
    chk("t4_beats", log_q.size(), 1);
    if (log_q.size() > 0) begin
      chk("t4_vb", log_q[0].vb, 19);
      chk("t4_dw0", log_q[0].d[255:224], 32'h4000_8001);
      chk("t4_ecrc", log_q[0].d[127:96], 32'hEC00_0004);
    end

    start_test();
    rdy_lo_from = cyc + 30;
    rdy_lo_len  = 5;
    add_tlp(3'b011, 0, 1'b0, 1'b0, 32'd0, 0);
    wait_done("t5_done");
    rdy_lo_from = -1;
    rdy_lo_len  = 0;
    chk("t5_beats", log_q.size(), 129);
    chk("t5_pops", pop_cnt, 257);
    if (log_q.size() == 129) begin
      chk("t5_last_vb", log_q[128].vb, 15);
      chk("t5_last_eot", log_q[128].eot, 1);
    end

    start_test();
    ent_q.push_back({1'b0, 1'b1, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677});
    wait_done("t6_done");
    chk("t6_err", err_cnt, 1);
    chk("t6_pops", pop_cnt, 1);
    chk("t6_beats", log_q.size(), 0);

    start_test();
    add_tlp(3'b011, 4, 1'b0, 1'b1, 32'd0, 0);
    wait_done("t7_done");
    chk("t7_err", err_cnt, 1);
    chk("t7_beats", log_q.size(), 1);

    start_test();
    add_tlp(3'b011, 16, 1'b0, 1'b0, 32'd0, 0);
    while (ent_q.size() > 1) void'(ent_q.pop_back());
    exp_q.delete();
    repeat (4) @(negedge clk);
    chk("t8_pops", pop_cnt, 1);
    ent_q.push_back({1'b1, 1'b1, 32'h0000_0001, 32'h1111_0001, 32'h1111_0002, 32'd0});
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("mid");
    ent_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_test();
    add_tlp(3'b000, 1, 1'b0, 1'b0, 32'd0, 0);
    wait_done("t8_done");
    chk("t8_beats", log_q.size(), 1);
    if (log_q.size() > 0) chk("t8_vb", log_q[0].vb, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
